mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between the instruction-fetch stage and the data-memory stage of the MIPS core.
- Sequences each access over a fixed memory latency.
- Returns read data with a one-cycle acknowledge pulse and produces per-requester stall signals for the pipeline control.
- Sits between the IF/MEM stages and the memory instance inside Top.

Parameters:
- LATENCY, 2: memory cycles per access (>=1); mem_* held stable for exactly LATENCY cycles.
- MAX_STREAK, 3: consecutive data grants allowed while fetch waits before fetch is forced.
- AW, 32: byte-address width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  AW  fetch byte address (program_counter)
- dm_req  in  1  data request, held until dm_ack
- dm_we  in  1  1=store, 0=load
- dm_addr  in  AW  data byte address
- dm_wdata  in  32  store data
- mem_req  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  AW  latched access address
- mem_wdata  out  32  latched store data
- mem_rdata  in  32  memory read data, valid in last BUSY cycle
- rdata  out  32  registered read data, valid with an ack
- if_ack  out  1  one-cycle fetch completion
- dm_ack  out  1  one-cycle data completion
- dm_err  out  1  one-cycle misaligned-data flag, coincident with dm_ack
- if_stall  out  1  if_req & ~if_ack
- dm_stall  out  1  dm_req & ~dm_ack

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, all acks/err=0, streak=0, owner=none. An access in flight is aborted; no ack for it.
- FSM states: IDLE, BUSY, RESP, ERR.
- IDLE: on a clock edge with any request, pick a winner and latch its address, we and wdata.
  - Misaligned dm_addr[1:0]!=0 winner -> ERR.
  - Otherwise -> BUSY with cnt=LATENCY-1.
  - No request -> stay in IDLE.
- Arbitration at grant: data wins over fetch unless if_req=1 and streak==MAX_STREAK; then fetch wins.
  - Streak increments on each data grant made while if_req=1.
  - Streak clears on a fetch grant, or on any grant where if_req=0.
- Fetch is always a read; if_addr[1:0] is ignored (forced to 00 on mem_addr).
- BUSY: mem_req=1, mem_we per latched op, mem_addr/mem_wdata stable.
  - cnt decrements each cycle.
  - At cnt==0 the edge captures mem_rdata into rdata and the FSM goes to RESP.
  - BUSY lasts exactly LATENCY cycles.
- RESP: mem_req=0; the owner's ack=1 for this single cycle; -> IDLE.
  - rdata holds until the next capture.
  - Stores leave rdata unchanged.
- ERR: no memory access; dm_ack=1 and dm_err=1 for one cycle; -> IDLE.
- Latency: grant edge to ack = LATENCY+1 cycles. Back-to-back throughput is one access per LATENCY+2 cycles, because IDLE is always visited.
- Requests sampled only in IDLE. Request/address changes during BUSY are ignored.
- Requester dropping req mid-access: the access still completes (a store is still written), and the ack still pulses; the requester ignores it.
- Simultaneous requests with streak<MAX_STREAK: data served first, fetch served in the next IDLE.
- Stalls are combinational from req and ack. Stall is 0 in the ack cycle, so the pipeline advances exactly then.

Test Plan:
- Reset mid-BUSY (LATENCY=2): assert rst_n=0 in the first BUSY cycle -> mem_req falls to 0 the same cycle; no if_ack or dm_ack follows after release.
- Lone fetch: if_req=1, if_addr=624, mem_rdata=0x20110005 in the 2nd BUSY cycle -> mem_addr=624 for 2 cycles, if_ack on the 3rd cycle after grant, rdata=0x20110005, if_stall high until then.
- Store then load: dm_we=1, addr=0x100, wdata=45, then load of 0x100 with the model returning 45 -> mem_we=1 for exactly 2 cycles; load rdata=45 with dm_ack; rdata unchanged after the store.
- Contention with fairness, MAX_STREAK=3, if_req and dm_req held high -> grant order D,D,D,F,D,D,D,F; each ack a single cycle.
- Misaligned load: dm_addr=0x102 -> mem_req stays 0; dm_ack=dm_err=1 one cycle after grant.
- Requester drop: dm_req is deasserted during BUSY of a store to 0x10 -> the memory write still occurs and dm_ack still pulses once.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Each access runs for a fixed LATENCY, then acks its owner for one cycle.
module mem_port_arbiter #(
  parameter int LATENCY    = 2,
  parameter int MAX_STREAK = 3,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   rdata,
  output logic          if_ack,
  output logic          dm_ack,
  output logic          dm_err,
  output logic          if_stall,
  output logic          dm_stall,
  output logic [1:0]    state_dbg
);

  // Handshake: a requester raises req with stable address/data and holds it
  // until its ack; ack is a one-cycle pulse and the stall drops in that cycle.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] streak;
  logic          owner_dm;

  logic fetch_forced;
  logic grant_dm;
  logic grant_if;
  logic dm_misaligned;
  logic unused_addr_bits;

  // Fetch is forced only once data has won MAX_STREAK times in a row over it.
  assign fetch_forced     = if_req && (streak == SW'(MAX_STREAK));
  assign grant_dm         = dm_req && !fetch_forced;
  assign grant_if         = if_req && !grant_dm;
  assign dm_misaligned    = (dm_addr[1:0] != 2'b00);
  assign unused_addr_bits = &{1'b0, if_addr[1:0]};

  assign if_stall  = if_req && !if_ack;
  assign dm_stall  = dm_req && !dm_ack;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      streak    <= '0;
      owner_dm  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      dm_err    <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      dm_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            owner_dm  <= 1'b1;
            streak    <= if_req ? (streak + SW'(1)) : '0;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (dm_misaligned) begin
              // Rejected without touching memory; the error acks immediately.
              dm_ack <= 1'b1;
              dm_err <= 1'b1;
              state  <= ERR;
            end else begin
              mem_req <= 1'b1;
              mem_we  <= dm_we;
              cnt     <= CW'(LATENCY - 1);
              state   <= BUSY;
            end
          end else if (grant_if) begin
            owner_dm <= 1'b0;
            streak   <= '0;
            mem_addr <= {if_addr[AW-1:2], 2'b00};
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            cnt      <= CW'(LATENCY - 1);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            if (!mem_we) begin
              rdata <= mem_rdata;
            end
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (owner_dm) begin
              dm_ack <= 1'b1;
            end else begin
              if_ack <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        ERR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (LATENCY=2, MAX_STREAK=3) with a
// word-addressed memory model behind the port.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] rdata;
  logic        if_ack;
  logic        dm_ack;
  logic        dm_err;
  logic        if_stall;
  logic        dm_stall;
  logic [1:0]  state_dbg;

  int total;
  int bad;

  // Memory model: preload port plus writes from the arbiter.
  logic [31:0] mem_model [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;
  int          we_cycles;

  logic [0:0]  exp_q[$];
  logic [0:0]  got_q[$];

  mem_port_arbiter #(.LATENCY(2), .MAX_STREAK(3), .AW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rdata     (rdata),
    .if_ack    (if_ack),
    .dm_ack    (dm_ack),
    .dm_err    (dm_err),
    .if_stall  (if_stall),
    .dm_stall  (dm_stall),
    .state_dbg (state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem_model[mem_addr[9:2]];

  always @(posedge clk) begin
    if (pre_we) begin
      mem_model[pre_idx] <= pre_val;
    end else if (mem_req && mem_we) begin
      mem_model[mem_addr[9:2]] <= mem_wdata;
      we_cycles <= we_cycles + 1;
    end
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_idx = idx;
    pre_val = val;
    pre_we  = 1'b1;
    @(negedge clk);
    pre_we  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int w0;
    int ack_cnt;
    int done_c;
    logic [31:0] last_addr;

    total = 0;
    bad = 0;
    we_cycles = 0;
    rst_n = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    dm_req = 1'b0;
    dm_we = 1'b0;
    dm_addr = '0;
    dm_wdata = '0;
    pre_we = 1'b0;
    pre_idx = '0;
    pre_val = '0;
    last_addr = '0;
    done_c = 0;

    preload(8'd156, 32'h20110005);
    preload(8'd16, 32'h11111111);
    preload(8'd32, 32'h22222222);
    tick();

    // Reset values
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_acks", {29'd0, if_ack, dm_ack, dm_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset during the first BUSY cycle aborts the access
    if_req = 1'b1;
    if_addr = 32'h40;
    tick();
    chk("abort_busy", 32'(state_dbg), 32'd1);
    chk("abort_mem_req_pre", 32'(mem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_mem_req_async", 32'(mem_req), 32'd0);
    chk("abort_state_async", 32'(state_dbg), 32'd0);
    if_req = 1'b0;
    tick();
    rst_n = 1'b1;
    ack_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if_ack || dm_ack) ack_cnt++;
    end
    chk("abort_no_ack", 32'(ack_cnt), 32'd0);

    // Lone fetch
    if_req = 1'b1;
    if_addr = 32'd624;
    #1;
    chk("fetch_stall_req", 32'(if_stall), 32'd1);
    tick();
    chk("fetch_b1_addr", mem_addr, 32'd624);
    chk("fetch_b1_req", 32'(mem_req), 32'd1);
    chk("fetch_b1_we", 32'(mem_we), 32'd0);
    chk("fetch_b1_stall", 32'(if_stall), 32'd1);
    tick();
    chk("fetch_b2_addr", mem_addr, 32'd624);
    chk("fetch_b2_req", 32'(mem_req), 32'd1);
    chk("fetch_b2_noack", 32'(if_ack), 32'd0);
    tick();
    chk("fetch_ack", 32'(if_ack), 32'd1);
    chk("fetch_rdata", rdata, 32'h20110005);
    chk("fetch_stall_ack", 32'(if_stall), 32'd0);
    chk("fetch_resp_req", 32'(mem_req), 32'd0);
    if_req = 1'b0;
    tick();
    chk("fetch_ack_drop", 32'(if_ack), 32'd0);
    chk("fetch_idle", 32'(state_dbg), 32'd0);

    // Store then load of 0x100
    w0 = we_cycles;
    dm_req = 1'b1;
    dm_we = 1'b1;
    dm_addr = 32'h100;
    dm_wdata = 32'd45;
    tick();
    chk("st_mem_we", 32'(mem_we), 32'd1);
    chk("st_mem_wdata", mem_wdata, 32'd45);
    tick();
    tick();
    chk("st_ack", 32'(dm_ack), 32'd1);
    chk("st_rdata_kept", rdata, 32'h20110005);
    chk("st_stall_ack", 32'(dm_stall), 32'd0);
    chk("st_we_cycles", 32'(we_cycles - w0), 32'd2);
    dm_we = 1'b0;
    tick();
    chk("ld_idle_noack", 32'(dm_ack), 32'd0);
    tick();
    tick();
    tick();
    chk("ld_ack", 32'(dm_ack), 32'd1);
    chk("ld_rdata", rdata, 32'd45);
    chk("ld_err", 32'(dm_err), 32'd0);
    dm_req = 1'b0;
    tick();

    // Misaligned load
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_addr = 32'h102;
    tick();
    chk("mis_ack", 32'(dm_ack), 32'd1);
    chk("mis_err", 32'(dm_err), 32'd1);
    chk("mis_mem_req", 32'(mem_req), 32'd0);
    chk("mis_state", 32'(state_dbg), 32'd3);
    chk("mis_rdata", rdata, 32'd45);
    dm_req = 1'b0;
    tick();
    chk("mis_ack_drop", {30'd0, dm_ack, dm_err}, 32'd0);
    chk("mis_mem_req2", 32'(mem_req), 32'd0);

    // Requester drops dm_req during a store
    w0 = we_cycles;
    dm_req = 1'b1;
    dm_we = 1'b1;
    dm_addr = 32'h10;
    dm_wdata = 32'hdeadbeef;
    tick();
    dm_req = 1'b0;
    chk("drop_addr", mem_addr, 32'h10);
    tick();
    tick();
    chk("drop_ack", 32'(dm_ack), 32'd1);
    chk("drop_stall", 32'(dm_stall), 32'd0);
    chk("drop_we_cycles", 32'(we_cycles - w0), 32'd2);
    tick();
    chk("drop_ack_once", 32'(dm_ack), 32'd0);
    chk("drop_mem_word", mem_model[4], 32'hdeadbeef);
    tick();
    chk("drop_no_regrant", 32'(mem_req), 32'd0);

    // Contention with both requests held: D,D,D,F,D,D,D,F
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    if_req = 1'b1;
    if_addr = 32'h42;
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_addr = 32'h80;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (mem_req) last_addr = mem_addr;
      if (if_ack || dm_ack) begin
        got_q.push_back(dm_ack);
        chk("cont_one_ack", 32'(if_ack && dm_ack), 32'd0);
        if (dm_ack) begin
          chk("cont_dm_rdata", rdata, 32'h22222222);
        end else begin
          chk("cont_if_rdata", rdata, 32'h11111111);
          chk("cont_if_addr", last_addr, 32'h40);
        end
        if (got_q.size() == 8) begin
          if_req = 1'b0;
          dm_req = 1'b0;
          done_c = c;
          break;
        end
      end
    end
    chk("cont_grants", 32'(got_q.size()), 32'd8);
    chk("cont_last_cycle", 32'(done_c), 32'd31);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("cont_order_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    tick();
    chk("cont_end_idle", 32'(state_dbg), 32'd0);
    chk("cont_end_acks", {30'd0, if_ack, dm_ack}, 32'd0);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
